// File: rtl/input_conditioner.sv
// Synchronises and debounces N_INPUTS raw board inputs, producing a clean level
// per channel plus registered single-cycle rise/fall pulses.
module input_conditioner #(
  parameter int unsigned N_INPUTS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                CLOCK,
  input  logic                RST,
  input  logic [N_INPUTS-1:0] RAW,
  output logic [N_INPUTS-1:0] LEVEL,
  output logic [N_INPUTS-1:0] RISE,
  output logic [N_INPUTS-1:0] FALL,
  output logic                CHANGED
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][N_INPUTS-1:0] sync_q, sync_d;
  logic [N_INPUTS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_INPUTS-1:0]                  level_q, level_d;
  logic [N_INPUTS-1:0]                  rise_q, rise_d;
  logic [N_INPUTS-1:0]                  fall_q, fall_d;
  logic [N_INPUTS-1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = RAW;
    for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
      sync_d[st] = sync_q[st-1];
    end
  end

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign LEVEL   = level_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign CHANGED = |(rise_q | fall_q);

endmodule
